// File: rtl/button_conditioner.sv
// Push-button front end: per-channel synchroniser, debounce FSM and edge/hold pulse generation.
// Outputs a clean level plus one-cycle press, release and long-hold pulses for each channel.
module button_conditioner #(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter int unsigned CNT_W           = 14,
    parameter int unsigned HOLD_CYCLES     = 1000000,
    parameter int unsigned HOLD_W          = 20
) (
    input  logic             clk,
    input  logic             res,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold
);

    localparam longint unsigned DC_LIMIT = 64'd1 << CNT_W;
    localparam longint unsigned HC_LIMIT = 64'd1 << HOLD_W;

    if (SYNC_STAGES < 2) begin : gen_err_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : gen_err_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (longint'(DEBOUNCE_CYCLES) > DC_LIMIT) begin : gen_err_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES-1");
    end
    if (longint'(HOLD_CYCLES) > HC_LIMIT) begin : gen_err_hold_w
        $error("HOLD_W too narrow for HOLD_CYCLES-1");
    end

    localparam logic [CNT_W-1:0] DC_MAX =
        CNT_W'(DEBOUNCE_CYCLES > 0 ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] HC_MAX =
        HOLD_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
    localparam bit HOLD_EN = (HOLD_CYCLES != 0);

    typedef enum logic [1:0] {
        StLow,
        StWaitHigh,
        StHigh,
        StWaitLow
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q [N_BTN];
    logic [N_BTN-1:0]       s;
    state_t                 state_q [N_BTN];
    logic [CNT_W-1:0]       dcnt_q [N_BTN];
    logic [HOLD_W-1:0]      hcnt_q [N_BTN];
    logic [N_BTN-1:0]       hold_done_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (res) begin
                sync_q[i] <= '0;
            end else begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
            end
        end
    end

    always_comb begin
        s = '0;
        for (int i = 0; i < N_BTN; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_hold    <= '0;
            hold_done_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= StLow;
                dcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
            end
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            btn_hold    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                unique case (state_q[i])
                    StLow: begin
                        if (s[i]) begin
                            state_q[i] <= StWaitHigh;
                            dcnt_q[i]  <= '0;
                        end
                    end
                    StWaitHigh: begin
                        if (!s[i]) begin
                            state_q[i] <= StLow;
                        end else if (dcnt_q[i] == DC_MAX) begin
                            state_q[i]   <= StHigh;
                            btn_level[i] <= 1'b1;
                            btn_press[i] <= 1'b1;
                            hcnt_q[i]    <= '0;
                        end else begin
                            dcnt_q[i] <= dcnt_q[i] + CNT_W'(1);
                        end
                    end
                    StHigh: begin
                        if (!s[i]) begin
                            state_q[i] <= StWaitLow;
                            dcnt_q[i]  <= '0;
                        end
                        // Hold timer only advances in StHigh, so it freezes across a WAIT_LOW bounce.
                        if (HOLD_EN && !hold_done_q[i]) begin
                            if (hcnt_q[i] == HC_MAX) begin
                                btn_hold[i]    <= 1'b1;
                                hold_done_q[i] <= 1'b1;
                            end else begin
                                hcnt_q[i] <= hcnt_q[i] + HOLD_W'(1);
                            end
                        end
                    end
                    StWaitLow: begin
                        if (s[i]) begin
                            state_q[i] <= StHigh;
                        end else if (dcnt_q[i] == DC_MAX) begin
                            state_q[i]     <= StLow;
                            btn_level[i]   <= 1'b0;
                            btn_release[i] <= 1'b1;
                            hold_done_q[i] <= 1'b0;
                        end else begin
                            dcnt_q[i] <= dcnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: state_q[i] <= StLow;
                endcase
            end
        end
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage for the stopwatch's push-button inputs (start/stop, lap, user reset).
- Synchronises each raw pad input to the system clock and debounces it with a per-button stability counter.
- Emits single-cycle press, release and long-hold pulses, plus a clean debounced level.
- Its press pulses drive the start/stop and lap toggle logic as clock-domain enables instead of raw pad edges. Its level output drives the user-reset path.

Parameters:
- N_BTN, 3, number of independent button channels.
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept a change (10 ms at 1 MHz); must be >=1.
- CNT_W, 14, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- HOLD_CYCLES, 1000000, cycles a debounced press must persist before btn_hold fires (1 s at 1 MHz); 0 disables hold detection.
- HOLD_W, 20, hold counter width; must hold HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock, 1 MHz.
- res  input  1  reset; one clock; reset is synchronous and active-high.
- btn_raw  input  N_BTN  asynchronous, bouncy button pad inputs; active-high.
- btn_level  output  N_BTN  debounced button state.
- btn_press  output  N_BTN  one-cycle pulse when btn_level rises.
- btn_release  output  N_BTN  one-cycle pulse when btn_level falls.
- btn_hold  output  N_BTN  one-cycle pulse, at most once per press, after HOLD_CYCLES of continuous debounced press.

Behaviour:
- **Channel independence.** Each channel is fully independent; identical logic is replicated N_BTN times. Simultaneous events on different channels are handled in the same cycle with no interaction.
- **Synchroniser.** A SYNC_STAGES-deep flop chain per channel. The last stage is s[i]. Only s[i] feeds the FSM.
- **Per-channel FSM states:** LOW, WAIT_HIGH, HIGH, WAIT_LOW. Each channel has a debounce counter dcnt (CNT_W) and a hold counter hcnt (HOLD_W).
- **LOW:**
  - If s==1: go to WAIT_HIGH, dcnt<=0.
- **WAIT_HIGH:**
  - If s==0: go to LOW (bounce rejected, no output change).
  - Else if dcnt==DEBOUNCE_CYCLES-1: go to HIGH, btn_level<=1, btn_press<=1, hcnt<=0.
  - Else dcnt<=dcnt+1.
- **HIGH:**
  - If s==0: go to WAIT_LOW, dcnt<=0.
  - Independently, while the channel is in HIGH and HOLD_CYCLES!=0:
    - If hcnt==HOLD_CYCLES-1: btn_hold<=1 for one cycle and a hold_done flag is set.
    - Else if !hold_done: hcnt<=hcnt+1.
    - hcnt saturates after the pulse.
    - hcnt and hold_done freeze while in WAIT_LOW and resume if the channel returns to HIGH.
- **WAIT_LOW:**
  - If s==1: go back to HIGH (bounce rejected, no pulse).
  - Else if dcnt==DEBOUNCE_CYCLES-1: go to LOW, btn_level<=0, btn_release<=1, hold_done<=0.
  - Else dcnt<=dcnt+1.
- **Pulse width.** btn_press, btn_release and btn_hold are registered and high for exactly one cycle. They default to 0 every cycle.
- **Latency.**
  - Raw input stable high from before edge 0: btn_level and btn_press are asserted after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Release latency is the same.
  - btn_hold is asserted HOLD_CYCLES cycles after btn_press.
- **Glitch rejection.** Any glitch shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no output change.
- **Reset (res==1 at a clock edge):**
  - All synchroniser flops go to 0.
  - All FSMs go to LOW.
  - dcnt, hcnt and hold_done go to 0.
  - btn_level, btn_press, btn_release and btn_hold are all 0.
  - Reset overrides all other activity.
- **Reset mid-operation.** A button held across reset deassertion is treated as a new press: btn_press fires SYNC_STAGES+DEBOUNCE_CYCLES cycles after res falls. No release pulse is generated for the press interrupted by reset.
- **Counter widths.** Counters never wrap: dcnt is cleared on every state entry and hcnt saturates. Overflow is a parameter error, checked by an elaboration-time assertion.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8 unless stated):
1. Assert res for 2 cycles, then btn_raw=3'b000 -> all outputs 0.
   Then btn_raw[0]=1 held from before edge 0 -> btn_level[0]=1 and btn_press[0]=1 after edge 6; btn_press[0]=0 after edge 7.
2. Bounce rejection: btn_raw[1] high for 3 cycles, low for 1, high for 2, then low -> btn_level[1] and btn_press[1] stay 0 throughout.
3. Press then release: btn_raw[0] high 20 cycles then low -> one btn_press pulse, then btn_release[0] exactly 6 cycles after the falling raw sample.
   Only one pulse of each; btn_level[0] low afterwards.
4. Long hold: btn_raw[2] held 30 cycles -> btn_hold[2] pulses once, 8 cycles after btn_press[2], and never again during the same press.
   Repeat with a press held 7 debounced cycles -> no btn_hold.
5. Simultaneous channels: btn_raw 3'b000->3'b101 in one cycle -> btn_press[0] and btn_press[2] assert in the same cycle; channel 1 is unaffected.
6. Reset mid-press: hold btn_raw[0]=1, pulse res high for 1 cycle while btn_level[0]=1 -> btn_level[0]=0 after the reset edge with no btn_release.
   A new btn_press[0] arrives 6 cycles after res deasserts.
